// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receive engine.
// Two-flop input synchroniser, majority-of-three mid-bit sampling, start-bit
// glitch rejection, optional odd/even parity, one or two stop bits, and a
// valid/ready output stage with overrun reporting.
`timescale 1ns/1ps

module uart_rx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic                  rx_en,
  input  logic                  RXD,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam int HALF  = CLKS_PER_BIT / 2;

  // Three sample points straddle the bit centre; the vote resolves on the last.
  localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic PAR_EN    = (PARITY != 0) ? 1'b1 : 1'b0;
  localparam logic PAR_ODD   = (PARITY == 1) ? 1'b1 : 1'b0;
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic                  perr;
  logic                  ferr;

  logic                  rxd_p0;
  logic                  rxd_p1;
  logic                  samp_a;
  logic                  samp_b;
  logic [DATA_WIDTH-1:0] shreg;

  logic                  maj;
  logic                  at_mid;
  logic                  bit_end;

  // Majority of three samples; a single corrupted sample cannot flip a bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity check: odd mode wants the XOR of data and parity bit to be 1,
  // even mode wants it to be 0. Returns 1 on mismatch.
  function automatic logic parity_bad(input logic [DATA_WIDTH-1:0] d,
                                      input logic                  p);
    return (^d) ^ p ^ PAR_ODD;
  endfunction

  // Sample-point decode and the majority vote using the live third sample.
  always_comb begin
    at_mid  = (count == SAMP_C);
    bit_end = (count == CNT_LAST);
    maj     = maj3(samp_a, samp_b, rxd_p1);
  end

  // --- stage p0/p1: two-flop synchroniser for the asynchronous serial line ---
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= RXD;
      rxd_p1 <= rxd_p0;
    end
  end

  // --- sampling: capture the first two votes and shift in resolved data bits ---
  always_ff @(posedge CLK100MHZ) begin
    if (count == SAMP_A) samp_a <= rxd_p1;
    if (count == SAMP_B) samp_b <= rxd_p1;
    if (rx_en && (state == S_DATA) && at_mid) shreg[bit_idx] <= maj;
  end

  // Frame FSM plus registered output stage (delivery, handshake, overrun).
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      count      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      count   <= count + 1'b1;

      // Consumer handshake; a delivery below in the same cycle overrides it.
      if (data_valid && data_ready) data_valid <= 1'b0;

      if (!rx_en) begin
        // Disabling mid-frame discards the partial word only.
        state <= S_IDLE;
        count <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            count <= '0;
            if (!rxd_p1) begin
              state <= S_START;
              busy  <= 1'b1;
              perr  <= 1'b0;
              ferr  <= 1'b0;
            end
          end

          S_START: begin
            if (at_mid && maj) begin
              // Line back high at the bit centre: treat as a glitch.
              state <= S_IDLE;
              count <= '0;
              busy  <= 1'b0;
            end else if (bit_end) begin
              state   <= S_DATA;
              count   <= '0;
              bit_idx <= '0;
            end
          end

          S_DATA: begin
            if (bit_end) begin
              count <= '0;
              if (bit_idx == IDX_LAST) begin
                state    <= PAR_EN ? S_PARITY : S_STOP;
                stop_idx <= 1'b0;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end

          S_PARITY: begin
            if (at_mid) perr <= parity_bad(shreg, maj);
            if (bit_end) begin
              state    <= S_STOP;
              count    <= '0;
              stop_idx <= 1'b0;
            end
          end

          S_STOP: begin
            if (at_mid) begin
              if (!maj) ferr <= 1'b1;
              if (stop_idx == STOP_LAST) begin
                // Leave at the centre of the final stop bit so a following
                // start edge is caught even with a slightly fast transmitter.
                state <= S_IDLE;
                count <= '0;
                busy  <= 1'b0;
                if (!data_valid || data_ready) begin
                  data_out   <= shreg;
                  parity_err <= perr;
                  frame_err  <= ferr | ~maj;
                  data_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else if (bit_end) begin
              count    <= '0;
              stop_idx <= 1'b1;
            end
          end

          default: begin
            state <= S_IDLE;
            count <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: three instances (8N1, 8E1, 7O2) fed from
// one serial driver; expected words are queued when a frame is sent and
// compared when the receiver presents them.
`timescale 1ns/1ps

module tb_uart_rx_frame;

  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];

  logic CLK100MHZ = 1'b0;
  logic reset     = 1'b0;
  logic line      = 1'b1;
  int   sel       = 0;

  logic rxd8, rxde, rxd7;
  assign rxd8 = (sel == 0) ? line : 1'b1;
  assign rxde = (sel == 1) ? line : 1'b1;
  assign rxd7 = (sel == 2) ? line : 1'b1;

  logic en8 = 1'b1, ene = 1'b1, en7 = 1'b1;
  logic rdy8 = 1'b0, rdye = 1'b0, rdy7 = 1'b0;

  logic [7:0] dout8, doute;
  logic [6:0] dout7;
  logic dv8, dve, dv7, pe8, pee, pe7, fe8, fee, fe7;
  logic ovr8, ovre, ovr7, busy8, busye, busy7;

  int   errors    = 0;
  int   checks    = 0;
  int   cyc       = 0;
  int   t_start   = 0;
  int   rises8    = 0;
  int   rise_cyc8 = 0;
  int   ovr_cnt8  = 0;
  logic dv8_q     = 1'b0;

  uart_rx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .rx_en(en8), .RXD(rxd8),
    .data_out(dout8), .data_valid(dv8), .data_ready(rdy8),
    .parity_err(pe8), .frame_err(fe8), .overrun(ovr8), .busy(busy8));

  uart_rx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .rx_en(ene), .RXD(rxde),
    .data_out(doute), .data_valid(dve), .data_ready(rdye),
    .parity_err(pee), .frame_err(fee), .overrun(ovre), .busy(busye));

  uart_rx_frame #(.DATA_WIDTH(7), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .rx_en(en7), .RXD(rxd7),
    .data_out(dout7), .data_valid(dv7), .data_ready(rdy7),
    .parity_err(pe7), .frame_err(fe7), .overrun(ovr7), .busy(busy7));

  always #5 CLK100MHZ = ~CLK100MHZ;

  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  // Track data_valid rises and overrun pulses of the 8N1 instance.
  always @(negedge CLK100MHZ) begin
    if (dv8 && !dv8_q) begin
      rises8    <= rises8 + 1;
      rise_cyc8 <= cyc;
    end
    if (ovr8) ovr_cnt8 <= ovr_cnt8 + 1;
    dv8_q <= dv8;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic get_dv(input int inst);
    case (inst)
      0:       return dv8;
      1:       return dve;
      default: return dv7;
    endcase
  endfunction

  function automatic logic [8:0] get_data(input int inst);
    case (inst)
      0:       return {1'b0, dout8};
      1:       return {1'b0, doute};
      default: return {2'b0, dout7};
    endcase
  endfunction

  function automatic logic get_pe(input int inst);
    case (inst)
      0:       return pe8;
      1:       return pee;
      default: return pe7;
    endcase
  endfunction

  function automatic logic get_fe(input int inst);
    case (inst)
      0:       return fe8;
      1:       return fee;
      default: return fe7;
    endcase
  endfunction

  task automatic set_rdy(input int inst, input logic v);
    case (inst)
      0:       rdy8 = v;
      1:       rdye = v;
      default: rdy7 = v;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  // Bit vector LSB-first: start, data, optional parity, stop bit(s).
  task automatic make_frame(input logic [8:0] d, input int dw, input int pm,
                            input logic pflip, input logic [1:0] stops, input int ns,
                            output logic [15:0] bits, output int n);
    logic x;
    x    = 1'b0;
    bits = '1;
    n    = 0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < dw; i++) begin
      bits[n] = d[i];
      x       = x ^ d[i];
      n++;
    end
    if (pm != 0) begin
      bits[n] = ((pm == 1) ? ~x : x) ^ pflip;
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      bits[n] = stops[i];
      n++;
    end
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    tick(1);
    for (int i = 0; i < n; i++) begin
      line = bits[i];
      if (i == 0) t_start = cyc;
      tick(CPB);
    end
    line = 1'b1;
  endtask

  task automatic send_word(input int inst, input logic [8:0] d, input int dw, input int pm,
                           input logic pflip, input logic [1:0] stops, input int ns,
                           input logic pe, input logic fe, input logic push);
    logic [15:0] bits;
    int          n;
    exp_t        e;
    make_frame(d, dw, pm, pflip, stops, ns, bits, n);
    sel = inst;
    if (push) begin
      e.d  = d;
      e.pe = pe;
      e.fe = fe;
      sb.push_back(e);
    end
    send_bits(bits, n);
  endtask

  task automatic wait_dv(input int inst, input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK100MHZ);
      seen = get_dv(inst);
    end
  endtask

  task automatic check_word(input int inst, input string tag);
    logic seen;
    exp_t e;
    wait_dv(inst, 400, seen);
    chk({tag, "_valid"}, seen, 1);
    chk({tag, "_sb"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, get_data(inst), e.d);
      chk({tag, "_perr"}, get_pe(inst), e.pe);
      chk({tag, "_ferr"}, get_fe(inst), e.fe);
    end
  endtask

  task automatic accept(input int inst, input string tag);
    tick(1);
    set_rdy(inst, 1'b1);
    tick(1);
    chk({tag, "_clr"}, get_dv(inst), 0);
    set_rdy(inst, 1'b0);
  endtask

  initial begin
    int          r0;
    int          o0;
    int          lat;
    logic [15:0] bits;
    int          n;

    // Reset state
    tick(3);
    chk("rst_data", dout8, 0);
    chk("rst_valid", dv8, 0);
    chk("rst_perr", pe8, 0);
    chk("rst_ferr", fe8, 0);
    chk("rst_ovr", ovr8, 0);
    chk("rst_busy", busy8, 0);
    reset = 1'b1;
    tick(5);

    // 8N1 0xA5: latency, hold while not ready, clear after accept
    send_word(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, 1'b0, 1'b0, 1'b1);
    check_word(0, "a5");
    tick(20);
    lat = rise_cyc8 - t_start;
    // 2 sync + 9 bit periods + ~9 into stop, allowing for decision-register phase
    chk("a5_latency", (lat >= 155 && lat <= 157), 1);
    chk("a5_hold_valid", dv8, 1);
    chk("a5_hold_data", dout8, 8'hA5);
    accept(0, "a5");

    // 6-cycle low pulse in idle: start rejected, no word
    r0 = rises8;
    sel = 0;
    tick(1);
    line = 1'b0;
    tick(6);
    chk("glitch_busy_hi", busy8, 1);
    line = 1'b1;
    tick(20);
    chk("glitch_busy_lo", busy8, 0);
    chk("glitch_valid", dv8, 0);
    chk("glitch_rises", rises8 - r0, 0);

    // Stop bit low: delivered with frame_err
    r0 = rises8;
    send_word(0, 9'h03C, 8, 0, 1'b0, 2'b00, 1, 1'b0, 1'b1, 1'b1);
    check_word(0, "ferr");
    accept(0, "ferr");
    tick(30);
    chk("ferr_busy", busy8, 0);
    chk("ferr_rises", rises8 - r0, 1);

    // Back-to-back while not ready: second word dropped, one overrun pulse
    o0 = ovr_cnt8;
    send_word(0, 9'h011, 8, 0, 1'b0, 2'b11, 1, 1'b0, 1'b0, 1'b1);
    send_word(0, 9'h022, 8, 0, 1'b0, 2'b11, 1, 1'b0, 1'b0, 1'b0);
    check_word(0, "ovr");
    tick(2);
    chk("ovr_pulses", ovr_cnt8 - o0, 1);
    accept(0, "ovr");

    // Even parity: correct then wrong parity bit
    send_word(1, 9'h03C, 8, 2, 1'b0, 2'b11, 1, 1'b0, 1'b0, 1'b1);
    check_word(1, "even_ok");
    accept(1, "even_ok");
    send_word(1, 9'h03C, 8, 2, 1'b1, 2'b11, 1, 1'b1, 1'b0, 1'b1);
    check_word(1, "even_bad");
    accept(1, "even_bad");

    // 7 data bits, odd parity, two stop bits; then second stop low
    send_word(2, 9'h055, 7, 1, 1'b0, 2'b11, 2, 1'b0, 1'b0, 1'b1);
    check_word(2, "o2_ok");
    accept(2, "o2_ok");
    send_word(2, 9'h055, 7, 1, 1'b0, 2'b01, 2, 1'b0, 1'b1, 1'b1);
    check_word(2, "o2_stop2");
    accept(2, "o2_stop2");
    tick(30);

    // Asynchronous reset during data bit 4, then a clean 0x0F
    r0 = rises8;
    make_frame(9'h0AA, 8, 0, 1'b0, 2'b11, 1, bits, n);
    sel = 0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      line = bits[i];
      tick(CPB);
    end
    line = bits[5];
    tick(8);
    chk("arst_busy_pre", busy8, 1);
    reset = 1'b0;
    #2;
    chk("arst_busy", busy8, 0);
    chk("arst_valid", dv8, 0);
    tick(3);
    line = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(30);
    chk("arst_rises", rises8 - r0, 0);
    send_word(0, 9'h00F, 8, 0, 1'b0, 2'b11, 1, 1'b0, 1'b0, 1'b1);
    check_word(0, "arst_0f");
    accept(0, "arst_0f");
    tick(5);
    chk("arst_one_word", rises8 - r0, 1);

    // rx_en dropped mid-frame: partial frame discarded
    r0 = rises8;
    make_frame(9'h077, 8, 0, 1'b0, 2'b11, 1, bits, n);
    sel = 0;
    send_bits(bits, 4);
    chk("en_busy_pre", busy8, 1);
    en8 = 1'b0;
    tick(1);
    chk("en_busy", busy8, 0);
    tick(5);
    en8 = 1'b1;
    tick(200);
    chk("en_rises", rises8 - r0, 0);
    chk("en_valid", dv8, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receive engine, successor to the fixed 8N1 receiver on the Nexys4DDR host link.
- Configurable in data width, baud divisor, parity mode and stop-bit count.
- Majority-vote mid-bit sampling, start-bit glitch rejection, parity/framing error reporting.
- Valid/ready output handshake with overrun detection.
- Sits between the RXD pin and the command/weight-loading logic.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal 5..9, LSB received first
CLKS_PER_BIT, 868, CLK100MHZ cycles per bit (115200 baud), legal >= 8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
CLK100MHZ  input  1  sole clock, all logic on posedge
reset  input  1  asynchronous, active-low; 0 forces reset state immediately
rx_en  input  1  receiver enable; 0 holds or returns FSM to IDLE
RXD  input  1  asynchronous serial line, idle high
data_out  output  DATA_WIDTH  received word, stable while data_valid=1
data_valid  output  1  word available; held until accepted
data_ready  input  1  consumer accepts word when data_valid & data_ready
parity_err  output  1  parity mismatch for presented word; qualified by data_valid
frame_err  output  1  any stop-bit majority sample = 0 for presented word; qualified by data_valid
overrun  output  1  one-cycle pulse: frame completed while previous word not yet accepted
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset=0): FSM=IDLE, baud/bit counters=0. Outputs: data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. Synchroniser flops preset to 1.
- RXD passes a 2-flop synchroniser; all references to RXD below mean the synchronised value (2-cycle input latency).
- Baud counter: counts 0..CLKS_PER_BIT-1 per bit; cleared on every state entry.
- Sample points: counts H-1, H, H+1, where H = CLKS_PER_BIT/2 (integer division). The bit value is the majority of the three samples, evaluated at count H+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_en=1 and RXD=0, go to START with count=0.
  - START: at H+1, majority=1 -> IDLE (glitch, no output). At count CLKS_PER_BIT-1 -> DATA, bit index=0.
  - DATA: majority stored into shift position [index]. At end of bit: if index=DATA_WIDTH-1 -> PARITY (PARITY!=0) or STOP; otherwise index+1.
  - PARITY: compare the majority with the computed parity; odd means the XOR of data and parity bit = 1, even means = 0. Result is latched as perr.
  - STOP: each stop bit majority=0 sets ferr. For the final stop bit, transition to IDLE at count H+1, not at bit end. This allows resync on back-to-back frames with up to ±2% baud error.
- Delivery: on the edge that leaves STOP:
  - If data_valid=0 or (data_valid & data_ready) in that cycle: load data_out, parity_err=perr, frame_err=ferr, set data_valid=1.
  - Else drop the new word, keep the old word and flags, pulse overrun=1 for one cycle.
  - Frames with errors are still delivered, with flags set.
- Handshake: data_valid falls on the edge after data_valid & data_ready, unless a new word loads in the same cycle (then it stays 1 with new contents). data_out, parity_err and frame_err must not change while data_valid=1 and data_ready=0.
- rx_en=0 mid-frame: FSM returns to IDLE next edge and the partial frame is discarded. An already-presented word and data_valid are unaffected.
- A start edge that arrives while data_valid=1 is received normally; overrun is decided only at delivery.
- Asynchronous reset mid-frame: all state cleared at once; no spurious data_valid after release.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5 -> data_out=0xA5, data_valid=1, parity_err=0, frame_err=0. data_valid asserts 2+16*9+9 cycles after the RXD falling edge. Holds until data_ready=1, then clears next edge.
- PARITY=2, send 0x3C with correct parity bit 0, then 0x3C with parity bit 1 -> first word parity_err=0, second word parity_err=1. Both delivered.
- 8N1, stop bit driven 0 -> frame_err=1, data_out matches sent byte. 6-cycle RXD low pulse in idle -> no start; FSM back to IDLE, busy drops, no data_valid.
- data_ready held 0, send 0x11 then 0x22 back-to-back -> data_out stays 0x11, one-cycle overrun pulse at second delivery. Then data_ready=1 -> data_valid clears.
- DATA_WIDTH=7, STOP_BITS=2, PARITY=1, send 0x55 -> data_out=0x55, no errors. Second stop bit low -> frame_err=1.
- Assert reset=0 mid-data-bit 4, release, send 0x0F -> only 0x0F delivered, no partial word. rx_en=0 mid-frame -> frame discarded, busy=0 next cycle.
